string_feeder: RTL and testbench

STRING_FEEDER -- requirements
Module: string_feeder

---
 rtl/string_feeder_if.sv | 43 ++++
 rtl/string_feeder.sv | 148 ++++++++++++++
 tb/tb_string_feeder.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/string_feeder_if.sv
// string_feeder_if -- bundles the buffer-write, stream-request and matcher-feed
// signals of string_feeder.
//   slave  (the feeder):   WR_EN, WR_ADDR, WR_DATA, LEN, START [, HOLD] in;
//                          EN, EN_A, STRING, BUSY, DONE out
//   master (the driver):   the reverse directions
// Optional: STRING_FEEDER_HOLD_EN adds the HOLD stall input.
interface string_feeder_if #(
  parameter int AW = 5
);
  logic          WR_EN;
  logic [AW-1:0] WR_ADDR;
  logic [7:0]    WR_DATA;
  logic [AW:0]   LEN;
  logic          START;
`ifdef STRING_FEEDER_HOLD_EN
  logic          HOLD;
`endif
  logic          EN;
  logic          EN_A;
  logic [7:0]    STRING;
  logic          BUSY;
  logic          DONE;

`ifdef STRING_FEEDER_HOLD_EN
  modport slave (
    input  WR_EN, WR_ADDR, WR_DATA, LEN, START, HOLD,
    output EN, EN_A, STRING, BUSY, DONE
  );
  modport master (
    output WR_EN, WR_ADDR, WR_DATA, LEN, START, HOLD,
    input  EN, EN_A, STRING, BUSY, DONE
  );
`else
  modport slave (
    input  WR_EN, WR_ADDR, WR_DATA, LEN, START,
    output EN, EN_A, STRING, BUSY, DONE
  );
  modport master (
    output WR_EN, WR_ADDR, WR_DATA, LEN, START,
    input  EN, EN_A, STRING, BUSY, DONE
  );
`endif
endinterface

// File: rtl/string_feeder.sv
// string_feeder -- byte buffer that streams buffer[0..LEN-1] to a string
// matcher, one character per clock, with matcher enable / advance strobes.
//   CLK   : clock, rising edge
//   RST   : asynchronous active-low reset
//   bus   : string_feeder_if.slave (write port, LEN/START request, EN/EN_A/
//           STRING feed, BUSY, DONE)
// Optional: define STRING_FEEDER_HOLD_EN to add bus.HOLD, which stalls the
// stream in FIRST/STREAM (outputs held, EN_A forced low).
module string_feeder #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic            CLK,
  input  logic            RST,
  string_feeder_if.slave  bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FIRST  = 2'd1;
  localparam logic [1:0] STREAM = 2'd2;
  localparam logic [1:0] FIN    = 2'd3;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [7:0]  buf_q [DEPTH];

  logic [1:0]  state_q, state_d;
  logic [AW:0] len_q, len_d;
  // idx_q is the index of the next byte to present
  logic [AW:0] idx_q, idx_d;
  logic        en_q, en_d;
  logic        ena_q, ena_d;
  logic [7:0]  str_q, str_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        wr_ok;
  logic        hold;
  logic [7:0]  byte0;

  // Buffer is locked while a stream is in progress
  assign wr_ok = bus.WR_EN && (state_q == IDLE);

`ifdef STRING_FEEDER_HOLD_EN
  assign hold = bus.HOLD;
`else
  assign hold = 1'b0;
`endif

  // A write to address 0 on the START edge must be visible as the first byte
  assign byte0 = (wr_ok && (bus.WR_ADDR == '0)) ? bus.WR_DATA : buf_q[0];

  // Buffer storage is deliberately not reset
  always_ff @(posedge CLK) begin
    if (wr_ok) begin
      buf_q[bus.WR_ADDR] <= bus.WR_DATA;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    en_d    = en_q;
    ena_d   = ena_q;
    str_d   = str_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        en_d  = 1'b0;
        ena_d = 1'b0;
        str_d = '0;
        if (bus.START && (bus.LEN != '0)) begin
          len_d   = (bus.LEN > DEPTH_L) ? DEPTH_L : bus.LEN;
          idx_d   = (AW+1)'(1);
          state_d = FIRST;
          en_d    = 1'b1;
          str_d   = byte0;
        end
      end
      // FIRST and STREAM differ only in what they are presenting; the next
      // step is the same: either the next byte or the FIN cycle.
      FIRST, STREAM: begin
        if (hold) begin
          ena_d = 1'b0;
        end else if (idx_q >= len_q) begin
          state_d = FIN;
          en_d    = 1'b0;
          ena_d   = 1'b0;
          str_d   = '0;
          done_d  = 1'b1;
          idx_d   = '0;
        end else begin
          state_d = STREAM;
          en_d    = 1'b1;
          ena_d   = 1'b1;
          str_d   = buf_q[idx_q[AW-1:0]];
          idx_d   = idx_q + (AW+1)'(1);
        end
      end
      FIN: begin
        state_d = IDLE;
        len_d   = '0;
        en_d    = 1'b0;
        ena_d   = 1'b0;
        str_d   = '0;
      end
      default: begin
        state_d = IDLE;
        len_d   = '0;
        idx_d   = '0;
        en_d    = 1'b0;
        ena_d   = 1'b0;
        str_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      en_q    <= 1'b0;
      ena_q   <= 1'b0;
      str_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      ena_q   <= ena_d;
      str_q   <= str_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.EN     = en_q;
  assign bus.EN_A   = ena_q;
  assign bus.STRING = str_q;
  assign bus.BUSY   = busy_q;
  assign bus.DONE   = done_q;

endmodule

// File: tb/tb_string_feeder.sv
// tb_string_feeder -- directed and randomized checks of string_feeder against
// a byte-array model of the buffer and the expected per-cycle stream shape.
module tb_string_feeder;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  string_feeder_if #(.AW(AW)) bus ();

  string_feeder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  logic [7:0] mem [DEPTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic en, input logic ena,
                           input logic [7:0] s, input logic busy, input logic done);
    chk({tag, ".EN"},     32'(bus.EN),     32'(en));
    chk({tag, ".EN_A"},   32'(bus.EN_A),   32'(ena));
    chk({tag, ".STRING"}, 32'(bus.STRING), 32'(s));
    chk({tag, ".BUSY"},   32'(bus.BUSY),   32'(busy));
    chk({tag, ".DONE"},   32'(bus.DONE),   32'(done));
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    bus.WR_EN   = 1'b1;
    bus.WR_ADDR = a[AW-1:0];
    bus.WR_DATA = d;
    tick();
    bus.WR_EN   = 1'b0;
    mem[a] = d;
  endtask

  // Requests a stream of length l and checks every cycle until back in IDLE.
  // poke_at: byte index at which START + WR_EN(addr0=0xFF) are attempted.
  // hold_at/hold_n: stall hold_n cycles after byte hold_at is presented.
  // wr0: write addr 0 together with START.
  task automatic do_stream(input int l, input int poke_at, input int hold_at,
                           input int hold_n, input bit wr0, input logic [7:0] wr0_data);
    int n;
    n = (l > DEPTH) ? DEPTH : l;
    bus.LEN   = l[AW:0];
    bus.START = 1'b1;
    if (wr0) begin
      bus.WR_EN   = 1'b1;
      bus.WR_ADDR = '0;
      bus.WR_DATA = wr0_data;
      mem[0] = wr0_data;
    end
    tick();
    bus.START = 1'b0;
    bus.WR_EN = 1'b0;
    if (n == 0) begin
      repeat (3) begin
        check_out("len0", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        tick();
      end
      return;
    end
    for (int j = 0; j < n; j++) begin
      check_out($sformatf("byte%0d", j), 1'b1, (j > 0), mem[j], 1'b1, 1'b0);
`ifdef STRING_FEEDER_HOLD_EN
      if (j == hold_at) begin
        for (int k = 0; k < hold_n; k++) begin
          bus.HOLD = 1'b1;
          tick();
          check_out($sformatf("held%0d", j), 1'b1, 1'b0, mem[j], 1'b1, 1'b0);
        end
        bus.HOLD = 1'b0;
      end
`else
      if (hold_at > DEPTH || hold_n < 0) $display("note: hold arguments unused");
`endif
      if (j == poke_at) begin
        bus.START   = 1'b1;
        bus.LEN     = 6'd3;
        bus.WR_EN   = 1'b1;
        bus.WR_ADDR = '0;
        bus.WR_DATA = 8'hFF;
      end
      tick();
      bus.START = 1'b0;
      bus.WR_EN = 1'b0;
    end
    check_out("fin", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    tick();
    check_out("idle", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    int l, h_at, h_n;
    bus.WR_EN   = 1'b0;
    bus.WR_ADDR = '0;
    bus.WR_DATA = '0;
    bus.LEN     = '0;
    bus.START   = 1'b0;
`ifdef STRING_FEEDER_HOLD_EN
    bus.HOLD    = 1'b0;
`endif

    // Reset state
    #2;
    check_out("reset", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    tick();
    RST = 1'b1;
    tick();

    // Fill the buffer with random bytes, then the ASCII pattern at 0..3
    for (int i = 0; i < DEPTH; i++) wr(i, 8'($urandom));
    wr(0, 8'h61); wr(1, 8'h62); wr(2, 8'h63); wr(3, 8'h64);

    // LEN=4 basic stream
    do_stream(4, -1, -1, 0, 1'b0, 8'h00);

    // LEN=1: single cycle, EN_A never high
    wr(0, 8'h7A);
    do_stream(1, -1, -1, 0, 1'b0, 8'h00);

    // LEN=0 is ignored; LEN=40 clamps to DEPTH
    do_stream(0, -1, -1, 0, 1'b0, 8'h00);
    do_stream(40, -1, -1, 0, 1'b0, 8'h00);
    do_stream(32, -1, -1, 0, 1'b0, 8'h00);

    // START and write to addr 0 during an active stream are ignored
    do_stream(5, 2, -1, 0, 1'b0, 8'h00);
    do_stream(3, -1, -1, 0, 1'b0, 8'h00);

    // Reset at the third byte of a LEN=8 stream
    bus.LEN   = 6'd8;
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    check_out("r_b0", 1'b1, 1'b0, mem[0], 1'b1, 1'b0);
    tick();
    check_out("r_b1", 1'b1, 1'b1, mem[1], 1'b1, 1'b0);
    tick();
    check_out("r_b2", 1'b1, 1'b1, mem[2], 1'b1, 1'b0);
    #2 RST = 1'b0;
    #1 check_out("rst_async", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    check_out("rst_hold", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    RST = 1'b1;
    do_stream(8, -1, -1, 0, 1'b0, 8'h00);

    // Write to addr 0 on the START edge is seen as the first byte
    do_stream(6, -1, -1, 0, 1'b1, 8'hA5);

`ifdef STRING_FEEDER_HOLD_EN
    wr(0, 8'h61); wr(1, 8'h62); wr(2, 8'h63); wr(3, 8'h64);
    do_stream(4, -1, 2, 2, 1'b0, 8'h00);
    do_stream(4, -1, 0, 1, 1'b0, 8'h00);
`endif

    // Randomized streams with interleaved buffer writes
    for (int it = 0; it < 10; it++) begin
      repeat ($urandom_range(1, 3)) wr($urandom_range(0, DEPTH - 1), 8'($urandom));
      l    = $urandom_range(0, 40);
      h_at = (l == 0) ? -1 : $urandom_range(0, ((l > DEPTH) ? DEPTH : l) - 1);
      h_n  = $urandom_range(0, 3);
      do_stream(l, ($urandom_range(0, 1) == 1) ? h_at : -1, h_at, h_n, 1'($urandom_range(0, 1)), 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
